pc_gen_btb: RTL and testbench
=============================

Name: pc_gen_btb

Overview:
Parametrised fetch-stage PC generator, successor to the single-cycle PC unit. Holds the fetch PC and supports a stall hold. Predicts taken control transfers with a direct-mapped branch target buffer (BTB) using 2-bit counters. Resolves mispredictions reported by the execute stage by redirecting the PC and raising a flush.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
BTB_ENTRIES, 16, BTB depth; power of two, >= 2; IDX_W = log2(BTB_ENTRIES)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
stall_F  in  1  hold pc_F this cycle
ex_valid  in  1  execute stage resolved a branch/jump this cycle
ex_pc  in  XLEN  PC of the resolved instruction
ex_taken  in  1  resolved direction
ex_target  in  XLEN  computed target (PC+imm or rs1+imm)
ex_jalr  in  1  target came from rs1+imm; bit 0 cleared before use
ex_pred_taken  in  1  prediction carried down the pipe with the instruction
ex_pred_target  in  XLEN  predicted target carried down the pipe
pc_F  out  XLEN  current fetch PC (registered)
pred_taken_F  out  1  BTB predicts pc_F taken
pred_target_F  out  XLEN  BTB target for pc_F
flush  out  1  combinational; mispredict this cycle, kill F/D
misalign_err  out  1  registered 1-cycle pulse; redirect target had bit 1 set

Behaviour:
- Reset (rst=1 at posedge): pc_F=RESET_PC, all BTB valid bits=0, misalign_err=0. flush is forced 0 while rst=1. BTB tag/target/counter contents are don't-care after reset.
- tgt_eff = ex_target with bit 0 forced to 0 when ex_jalr=1; otherwise tgt_eff = ex_target.
- mispredict = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & (tgt_eff != ex_pred_target))). flush = mispredict & ~rst.
- Next-PC priority at posedge:
  1. rst
  2. mispredict: ex_taken ? {tgt_eff[XLEN-1:2],2'b00} : ex_pc+4
  3. stall_F: hold
  4. pred_taken_F: pred_target_F
  5. pc_F+4
- Redirect overrides stall. All adds wrap modulo 2^XLEN.
- misalign_err is set the cycle after a mispredict redirect with ex_taken=1 and tgt_eff[1]=1; otherwise 0. The redirect still proceeds, to the word-aligned target.
- BTB lookup is combinational on pc_F:
  - index = pc_F[IDX_W+1:2]; tag = pc_F[XLEN-1:IDX_W+2].
  - hit = valid & tag match.
  - pred_taken_F = hit & ctr[1]; pred_target_F = stored target. When hit=0, pred_target_F = pc_F+4.
- BTB update at posedge when ex_valid=1 and rst=0, indexed and tagged by ex_pc:
  - Hit: ctr saturating +1 if taken, -1 if not taken (00..11). If taken, target <= tgt_eff with bits[1:0] cleared.
  - Miss and taken: allocate (overwrite entry); valid=1, tag, target, ctr=2'b10.
  - Miss and not taken: no change.
- Update is independent of stall_F and happens on both predicted and mispredicted resolutions.
- Same-cycle lookup and update of one entry: lookup sees the pre-update contents. The write is visible next cycle.
- Reset asserted mid-operation overrides everything: no BTB write occurs that cycle, and misalign_err clears.
- Latency: pc_F changes one cycle after the deciding inputs; flush is zero-latency.

Decomposition:
- Package pc_pkg:
  - btb_entry_t struct {valid, tag, target, ctr[1:0]}
  - CTR_WEAK_TAKEN = 2'b10, CTR_MAX = 2'b11
  - INST_BYTES = 4
  - idx_w/tag_w helper functions
- Sub-module btb: storage array, lookup port, update port with counter logic.
- The top level holds the PC register, next-PC mux, and mispredict/flush logic.

Test Plan:
- Reset, then 4 cycles free-run -> pc_F = 0,4,8,12,16; pred_taken_F=0; flush=0.
- stall_F=1 for 3 cycles at pc_F=0x10 -> pc_F holds 0x10. Release -> 0x14.
- First encounter: ex_valid, ex_pc=0x20, taken, tgt=0x100, pred_taken=0 -> flush=1 same cycle; pc_F=0x100 next cycle. When pc_F later returns to 0x20 -> pred_taken_F=1, pred_target_F=0x100.
- Counter hysteresis: entry at 0x20 with ctr=10, resolved not-taken once -> ctr=01, pred_taken_F=0 for 0x20. Resolve taken twice -> ctr=11, predicts taken.
- JALR: ex_jalr=1, target 0x203 (bit 0 cleared to 0x202), pred_taken=0 -> pc_F=0x200 and misalign_err pulses 1 cycle. Also cover redirect with stall_F=1 -> redirect wins.
- Wrap: pc_F=32'hFFFF_FFFC, no prediction -> pc_F=0. Assert rst mid-redirect -> pc_F=RESET_PC, flush=0, BTB empty (no prediction at 0x20).

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage PC generator and its branch target buffer.
package pc_pkg;

  localparam int unsigned PC_W_MAX   = 32;
  localparam int unsigned INST_BYTES = 4;

  localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;
  localparam logic [1:0] CTR_MAX        = 2'b11;

  // Tag and target fields are sized for the widest supported PC; narrower tags are zero-extended.
  typedef struct packed {
    logic                valid;
    logic [PC_W_MAX-1:0] tag;
    logic [PC_W_MAX-1:0] target;
    logic [1:0]          ctr;
  } btb_entry_t;

  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  function automatic int unsigned tag_w(input int unsigned xlen, input int unsigned entries);
    return xlen - idx_w(entries) - 2;
  endfunction

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational on a word address; updates land at the next clock edge.
module btb
  import pc_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-3:0] i_lk_word,
  output logic            o_hit,
  output logic            o_taken,
  output logic [XLEN-1:0] o_target,
  input  logic            i_upd_en,
  input  logic [XLEN-3:0] i_upd_word,
  input  logic            i_upd_taken,
  input  logic [XLEN-1:0] i_upd_target
);

  localparam int unsigned IDX_W = idx_w(ENTRIES);
  localparam int unsigned TAG_W = tag_w(XLEN, ENTRIES);

  btb_entry_t r_mem [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  btb_entry_t       w_lk;
  btb_entry_t       w_up;
  btb_entry_t       w_new;
  logic             w_up_hit;
  logic             w_we;

  assign w_lk_idx = i_lk_word[IDX_W-1:0];
  assign w_lk_tag = i_lk_word[XLEN-3:IDX_W];
  assign w_up_idx = i_upd_word[IDX_W-1:0];
  assign w_up_tag = i_upd_word[XLEN-3:IDX_W];

  assign w_lk     = r_mem[w_lk_idx];
  assign o_hit    = w_lk.valid && (w_lk.tag == PC_W_MAX'(w_lk_tag));
  assign o_taken  = o_hit && w_lk.ctr[1];
  assign o_target = w_lk.target[XLEN-1:0];

  assign w_up     = r_mem[w_up_idx];
  assign w_up_hit = w_up.valid && (w_up.tag == PC_W_MAX'(w_up_tag));

  // Counter training on a hit; allocation only for taken misses.
  always_comb begin
    w_new = w_up;
    w_we  = 1'b0;
    if (i_upd_en) begin
      if (w_up_hit) begin
        w_we = 1'b1;
        if (i_upd_taken) begin
          if (w_up.ctr != CTR_MAX) w_new.ctr = w_up.ctr + 2'd1;
          w_new.target = PC_W_MAX'(i_upd_target);
        end else if (w_up.ctr != 2'b00) begin
          w_new.ctr = w_up.ctr - 2'd1;
        end
      end else if (i_upd_taken) begin
        w_we         = 1'b1;
        w_new.valid  = 1'b1;
        w_new.tag    = PC_W_MAX'(w_up_tag);
        w_new.target = PC_W_MAX'(i_upd_target);
        w_new.ctr    = CTR_WEAK_TAKEN;
      end
    end
  end

  // Only valid bits are cleared on reset; payload is don't-care until allocated.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) r_mem[i].valid <= 1'b0;
    end else if (w_we) begin
      r_mem[w_up_idx] <= w_new;
    end
  end

endmodule

// File: rtl/pc_gen_btb.sv
// Fetch-stage PC generator: PC register, next-PC selection with BTB prediction,
// and mispredict redirect/flush from the execute stage.
module pc_gen_btb
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_F,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_jalr,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc_F,
  output logic            pred_taken_F,
  output logic [XLEN-1:0] pred_target_F,
  output logic            flush,
  output logic            misalign_err
);

  logic [XLEN-1:0] r_pc;
  logic            r_misalign;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_ex_plus4;
  logic [XLEN-1:0] w_tgt_eff;
  logic [XLEN-1:0] w_tgt_aligned;
  logic            w_mispredict;
  logic            w_btb_hit;
  logic            w_btb_taken;
  logic [XLEN-1:0] w_btb_target;

  assign w_pc_plus4    = r_pc + XLEN'(INST_BYTES);
  assign w_ex_plus4    = ex_pc + XLEN'(INST_BYTES);
  assign w_tgt_eff     = ex_jalr ? {ex_target[XLEN-1:1], 1'b0} : ex_target;
  assign w_tgt_aligned = {w_tgt_eff[XLEN-1:2], 2'b00};

  assign w_mispredict = ex_valid &&
                        ((ex_taken != ex_pred_taken) ||
                         (ex_taken && (w_tgt_eff != ex_pred_target)));
  assign flush        = w_mispredict && !rst;

  btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .i_lk_word    (r_pc[XLEN-1:2]),
    .o_hit        (w_btb_hit),
    .o_taken      (w_btb_taken),
    .o_target     (w_btb_target),
    .i_upd_en     (ex_valid && !rst),
    .i_upd_word   (ex_pc[XLEN-1:2]),
    .i_upd_taken  (ex_taken),
    .i_upd_target (w_tgt_aligned)
  );

  assign pred_taken_F  = w_btb_taken;
  assign pred_target_F = w_btb_hit ? w_btb_target : w_pc_plus4;

  // Redirect beats stall, stall beats prediction.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_mispredict) begin
      w_pc_next = ex_taken ? w_tgt_aligned : w_ex_plus4;
    end else if (stall_F) begin
      w_pc_next = r_pc;
    end else if (pred_taken_F) begin
      w_pc_next = pred_target_F;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_misalign <= w_mispredict && ex_taken && w_tgt_eff[1];
    end
  end

  assign pc_F         = r_pc;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_gen_btb.sv
// Self-checking bench for pc_gen_btb: table of per-cycle vectors with hand-derived
// expectations, routed through an expected-value queue.
module tb_pc_gen_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_F;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_jalr;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] pc_F;
  logic        pred_taken_F;
  logic [31:0] pred_target_F;
  logic        flush;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;

  pc_gen_btb #(
    .XLEN        (32),
    .RESET_PC    (32'h0000_0000),
    .BTB_ENTRIES (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_F        (stall_F),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_jalr        (ex_jalr),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .pc_F           (pc_F),
    .pred_taken_F   (pred_taken_F),
    .pred_target_F  (pred_target_F),
    .flush          (flush),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        exv;
    logic [31:0] expc;
    logic        extk;
    logic [31:0] extgt;
    logic        jalr;
    logic        expt;
    logic [31:0] exptgt;
    logic        e_flush;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic add(input logic r, input logic st, input logic v, input logic [31:0] p,
                     input logic tk, input logic [31:0] tg, input logic j, input logic pt,
                     input logic [31:0] ptg, input logic ef, input logic ept,
                     input logic [31:0] eptg, input logic [31:0] epc, input logic em);
    vec_t t;
    t.rst = r; t.stall = st; t.exv = v; t.expc = p; t.extk = tk; t.extgt = tg;
    t.jalr = j; t.expt = pt; t.exptgt = ptg; t.e_flush = ef; t.e_pt = ept;
    t.e_ptgt = eptg; t.e_pc = epc; t.e_mis = em;
    tbl.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; stall_F = t.stall; ex_valid = t.exv; ex_pc = t.expc;
    ex_taken = t.extk; ex_target = t.extgt; ex_jalr = t.jalr;
    ex_pred_taken = t.expt; ex_pred_target = t.exptgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t cur;
    // Free-run from reset
    add(0,0,0,0,0,0,0,0,0, 0,0,32'h04,32'h04,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,32'h08,32'h08,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,32'h0C,32'h0C,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,32'h10,32'h10,0);
    // Stall hold, then release
    add(0,1,0,0,0,0,0,0,0, 0,0,32'h14,32'h10,0);
    add(0,1,0,0,0,0,0,0,0, 0,0,32'h14,32'h10,0);
    add(0,1,0,0,0,0,0,0,0, 0,0,32'h14,32'h10,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,32'h14,32'h14,0);
    // First encounter of taken branch at 0x20 -> allocate ctr=10
    add(0,0,1,32'h20,1,32'h100,0,0,0,         1,0,32'h18,32'h100,0);
    add(0,0,1,32'h1C,0,0,0,1,32'h20,          1,0,32'h104,32'h20,0);
    add(0,0,0,0,0,0,0,0,0,                    0,1,32'h100,32'h100,0);
    // Not taken once -> ctr=01, no longer predicted
    add(0,0,1,32'h20,0,0,0,1,32'h100,         1,0,32'h104,32'h24,0);
    add(0,0,1,32'h1C,0,0,0,1,32'h20,          1,0,32'h28,32'h20,0);
    // Same-cycle lookup sees ctr=01 while update moves it to 10
    add(0,0,1,32'h20,1,32'h100,0,0,0,         1,0,32'h100,32'h100,0);
    add(0,0,1,32'h20,1,32'h100,0,1,32'h100,   0,0,32'h104,32'h104,0);
    add(0,0,1,32'h1C,0,0,0,1,32'h20,          1,0,32'h108,32'h20,0);
    add(0,0,0,0,0,0,0,0,0,                    0,1,32'h100,32'h100,0);
    // ctr=11 -> one not-taken leaves 10, still predicted taken
    add(0,0,1,32'h20,0,0,0,1,32'h100,         1,0,32'h104,32'h24,0);
    add(0,0,1,32'h1C,0,0,0,1,32'h20,          1,0,32'h28,32'h20,0);
    add(0,0,0,0,0,0,0,0,0,                    0,1,32'h100,32'h100,0);
    // JALR to 0x203 while stalled: redirect to 0x200, misalign pulse
    add(0,1,1,32'h40,1,32'h203,1,0,0,         1,0,32'h104,32'h200,1);
    add(0,0,0,0,0,0,0,0,0,                    0,0,32'h204,32'h204,0);
    // Wrap at top of address space
    add(0,0,1,32'h64,1,32'hFFFF_FFFC,0,0,0,   1,0,32'h208,32'hFFFF_FFFC,0);
    add(0,0,0,0,0,0,0,0,0,                    0,0,32'h0,32'h0,0);
    add(0,0,0,0,0,0,0,0,0,                    0,0,32'h04,32'h04,0);
    // Reset during a redirect: flush forced low, BTB write suppressed and cleared
    add(1,0,1,32'h20,1,32'h300,0,0,0,         0,0,32'h08,32'h0,0);
    add(0,0,1,32'h1C,0,0,0,1,32'h20,          1,0,32'h04,32'h20,0);
    add(0,0,0,0,0,0,0,0,0,                    0,0,32'h24,32'h24,0);

    // Initial reset with a would-be mispredict on the execute inputs
    rst = 1'b1; stall_F = 1'b0; ex_valid = 1'b1; ex_pc = 32'h20; ex_taken = 1'b1;
    ex_target = 32'h100; ex_jalr = 1'b0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    @(posedge clk);
    #1 chk("rst_flush", 32'(flush), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_pc", pc_F, 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'h0);
    chk("rst_pred_taken", 32'(pred_taken_F), 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      #2;
      cur = exp_q.pop_front();
      chk($sformatf("flush[%0d]", i), 32'(flush), 32'(cur.e_flush));
      chk($sformatf("pred_taken[%0d]", i), 32'(pred_taken_F), 32'(cur.e_pt));
      chk($sformatf("pred_target[%0d]", i), pred_target_F, cur.e_ptgt);
      @(posedge clk);
      #1;
      chk($sformatf("pc_F[%0d]", i), pc_F, cur.e_pc);
      chk($sformatf("misalign[%0d]", i), 32'(misalign_err), 32'(cur.e_mis));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
